// File: rtl/nn_layer_sequencer.sv
// Multi-layer fully-connected inference engine: N_IN parallel MAC units stream weight rows
// from a synchronous-read memory, then activate, scale and saturate, once per layer.
module nn_layer_sequencer #(
  parameter int unsigned N_IN     = 4,
  parameter int unsigned N_LAYERS = 2,
  parameter int unsigned DW       = 8,
  parameter int unsigned WW       = 8,
  parameter int unsigned FRAC     = 0,
  parameter int unsigned AW       = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               act_sel,
  input  logic [N_IN*DW-1:0] in_data,
  output logic               w_rd,
  output logic [AW-1:0]      w_addr,
  input  logic [N_IN*WW-1:0] w_data,
  output logic               busy,
  output logic               done,
  output logic [N_IN*DW-1:0] out_data
);

  localparam int unsigned ACCW = DW + WW + $clog2(N_IN);
  localparam int unsigned JW   = $clog2(N_IN);
  localparam int unsigned LW   = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;
  localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'((1 << (DW - 1)) - 1);
  localparam logic signed [ACCW-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_ACT, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [JW-1:0]         j_q, j_d;
  logic [LW-1:0]         layer_q, layer_d;
  logic                  w_rd_q, w_rd_d;
  logic [AW-1:0]         w_addr_q, w_addr_d;
  logic                  mac_en_q, mac_en_d;
  logic [JW-1:0]         mac_j_q, mac_j_d;
  logic                  act_sel_q, act_sel_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [N_IN*DW-1:0]    out_data_q, out_data_d;
  logic signed [DW-1:0]  data_q [N_IN];
  logic signed [DW-1:0]  data_d [N_IN];
  logic signed [ACCW-1:0] acc_q [N_IN];
  logic signed [ACCW-1:0] acc_d [N_IN];
  logic signed [ACCW-1:0] shifted [N_IN];
  logic signed [DW-1:0]  act_y [N_IN];
  logic                  clr_acc;

  // Scale, saturate and optionally rectify each accumulator.
  always_comb begin
    for (int u = 0; u < N_IN; u++) begin
      shifted[u] = acc_q[u] >>> FRAC;
      if (shifted[u] > SAT_MAX)      act_y[u] = SAT_MAX[DW-1:0];
      else if (shifted[u] < SAT_MIN) act_y[u] = SAT_MIN[DW-1:0];
      else                           act_y[u] = shifted[u][DW-1:0];
      if (!act_sel_q && act_y[u][DW-1]) act_y[u] = '0;
    end
  end

  // MAC stage runs one cycle behind the weight read that feeds it.
  always_comb begin
    for (int u = 0; u < N_IN; u++) begin
      acc_d[u] = acc_q[u];
      if (mac_en_q)
        acc_d[u] = acc_q[u] + ACCW'(data_q[mac_j_q]) * ACCW'($signed(w_data[u*WW +: WW]));
      if (clr_acc) acc_d[u] = '0;
    end
  end

  always_comb begin
    state_d    = state_q;
    j_d        = j_q;
    layer_d    = layer_q;
    w_rd_d     = 1'b0;
    w_addr_d   = w_addr_q;
    mac_en_d   = w_rd_q;
    mac_j_d    = j_q;
    act_sel_d  = act_sel_q;
    out_data_d = out_data_q;
    clr_acc    = 1'b0;
    data_d     = data_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_FETCH;
          act_sel_d = act_sel;
          layer_d   = '0;
          j_d       = '0;
          clr_acc   = 1'b1;
          w_rd_d    = 1'b1;
          w_addr_d  = '0;
          for (int k = 0; k < N_IN; k++) data_d[k] = in_data[k*DW +: DW];
        end
      end
      S_FETCH: begin
        if (j_q == JW'(N_IN - 1)) begin
          state_d = S_DRAIN;
        end else begin
          j_d      = j_q + 1'b1;
          w_rd_d   = 1'b1;
          w_addr_d = w_addr_q + 1'b1;
        end
      end
      S_DRAIN: state_d = S_ACT;
      S_ACT: begin
        clr_acc = 1'b1;
        for (int u = 0; u < N_IN; u++) data_d[u] = act_y[u];
        if (layer_q == LW'(N_LAYERS - 1)) begin
          state_d = S_DONE;
          for (int u = 0; u < N_IN; u++) out_data_d[u*DW +: DW] = act_y[u];
        end else begin
          // Row addresses are contiguous across layers, so the next layer continues at +1.
          state_d  = S_FETCH;
          layer_d  = layer_q + 1'b1;
          j_d      = '0;
          w_rd_d   = 1'b1;
          w_addr_d = w_addr_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_FETCH) || (state_d == S_DRAIN) || (state_d == S_ACT);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      j_q        <= '0;
      layer_q    <= '0;
      w_rd_q     <= 1'b0;
      w_addr_q   <= '0;
      mac_en_q   <= 1'b0;
      mac_j_q    <= '0;
      act_sel_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      out_data_q <= '0;
      for (int u = 0; u < N_IN; u++) begin
        data_q[u] <= '0;
        acc_q[u]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      j_q        <= j_d;
      layer_q    <= layer_d;
      w_rd_q     <= w_rd_d;
      w_addr_q   <= w_addr_d;
      mac_en_q   <= mac_en_d;
      mac_j_q    <= mac_j_d;
      act_sel_q  <= act_sel_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      out_data_q <= out_data_d;
      data_q     <= data_d;
      acc_q      <= acc_d;
    end
  end

  assign w_rd     = w_rd_q;
  assign w_addr   = w_addr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign out_data = out_data_q;

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Directed bench for nn_layer_sequencer: default instance plus a FRAC=2 instance,
// each with its own 1-cycle-latency weight memory.
module tb_nn_layer_sequencer;

  localparam int unsigned AW = 7;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        act_sel;
  logic [31:0] in_data;
  logic        w_rd0, w_rd1, busy0, busy1, done0, done1;
  logic [AW-1:0] w_addr0, w_addr1;
  logic [31:0] w_data0, w_data1, out0, out1;
  logic [31:0] mem0 [8];
  logic [31:0] mem1 [8];

  int n_tests = 0;
  int n_fail  = 0;
  int first_done, second_done, done_cnt, first_done1;
  logic          busy_h [0:40];
  logic          wrd_h  [0:40];
  logic [AW-1:0] addr_h [0:40];

  always #5 clk = ~clk;

  nn_layer_sequencer dut0 (
    .clk(clk), .reset(reset), .start(start), .act_sel(act_sel), .in_data(in_data),
    .w_rd(w_rd0), .w_addr(w_addr0), .w_data(w_data0),
    .busy(busy0), .done(done0), .out_data(out0)
  );

  nn_layer_sequencer #(.FRAC(2)) dut1 (
    .clk(clk), .reset(reset), .start(start), .act_sel(act_sel), .in_data(in_data),
    .w_rd(w_rd1), .w_addr(w_addr1), .w_data(w_data1),
    .busy(busy1), .done(done1), .out_data(out1)
  );

  // Weight memories; junk on the bus whenever no read was issued.
  always @(posedge clk) begin
    w_data0 <= w_rd0 ? mem0[w_addr0[2:0]] : $urandom();
    w_data1 <= w_rd1 ? mem1[w_addr1[2:0]] : $urandom();
  end

  task automatic load_identity();
    for (int j = 0; j < 8; j++) mem0[j] = 32'h1 << (8 * (j % 4));
  endtask

  task automatic run_watch(input logic [31:0] vec, input logic act, input int ncyc,
                           input int pulse_cyc, input logic hold);
    first_done = -1; second_done = -1; done_cnt = 0; first_done1 = -1;
    @(negedge clk);
    in_data = vec; act_sel = act; start = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      busy_h[c] = busy0; wrd_h[c] = w_rd0; addr_h[c] = w_addr0;
      if (done0) begin
        done_cnt++;
        if (first_done < 0) first_done = c;
        else if (second_done < 0) second_done = c;
      end
      if (done1 && first_done1 < 0) first_done1 = c;
      start = (hold && c < 15) || (c == pulse_cyc);
      if ((c == 1 && !hold) || c == pulse_cyc) begin
        in_data = vec ^ 32'h11223344; act_sel = ~act;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; act_sel = 1'b0; in_data = '0;
    repeat (3) @(negedge clk);
    n_tests++; if (busy0 !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy0); end
    n_tests++; if (done0 !== 1'b0)  begin n_fail++; $display("FAIL reset_done: got %b want 0", done0); end
    n_tests++; if (w_rd0 !== 1'b0)  begin n_fail++; $display("FAIL reset_w_rd: got %b want 0", w_rd0); end
    n_tests++; if (w_addr0 !== '0)  begin n_fail++; $display("FAIL reset_w_addr: got %h want 0", w_addr0); end
    n_tests++; if (out0 !== 32'h0)  begin n_fail++; $display("FAIL reset_out: got %h want 0", out0); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_identity_linear();
    load_identity();
    run_watch(32'h0007FD05, 1'b1, 20, -1, 1'b0);
    n_tests++; if (out0 !== 32'h0007FD05) begin n_fail++; $display("FAIL ident_lin_out: got %h want 0007fd05", out0); end
    n_tests++; if (first_done !== 13) begin n_fail++; $display("FAIL ident_done_cycle: got %0d want 13", first_done); end
    n_tests++; if (done_cnt !== 1) begin n_fail++; $display("FAIL ident_done_count: got %0d want 1", done_cnt); end
    for (int c = 1; c <= 14; c++) begin
      n_tests++;
      if (busy_h[c] !== (c <= 12)) begin
        n_fail++; $display("FAIL ident_busy_c%0d: got %b want %b", c, busy_h[c], (c <= 12));
      end
    end
  endtask

  task automatic test_relu_addr();
    logic          exp_rd;
    logic [AW-1:0] exp_addr;
    load_identity();
    run_watch(32'h0007FD05, 1'b0, 20, -1, 1'b0);
    n_tests++; if (out0 !== 32'h00070005) begin n_fail++; $display("FAIL relu_out: got %h want 00070005", out0); end
    for (int c = 1; c <= 12; c++) begin
      exp_rd   = (c >= 1 && c <= 4) || (c >= 7 && c <= 10);
      exp_addr = (c <= 4) ? AW'(c - 1) : AW'(c - 3);
      n_tests++;
      if (wrd_h[c] !== exp_rd) begin
        n_fail++; $display("FAIL relu_w_rd_c%0d: got %b want %b", c, wrd_h[c], exp_rd);
      end
      if (exp_rd) begin
        n_tests++;
        if (addr_h[c] !== exp_addr) begin
          n_fail++; $display("FAIL relu_w_addr_c%0d: got %0d want %0d", c, addr_h[c], exp_addr);
        end
      end
    end
  endtask

  task automatic test_saturation();
    for (int j = 0; j < 8; j++) mem0[j] = 32'h7F7F7F7F;
    run_watch(32'h7F7F7F7F, 1'b1, 16, -1, 1'b0);
    n_tests++; if (out0 !== 32'h7F7F7F7F) begin n_fail++; $display("FAIL sat_pos: got %h want 7f7f7f7f", out0); end
    for (int j = 0; j < 8; j++) mem0[j] = 32'h81818181;
    run_watch(32'h7F7F7F7F, 1'b1, 16, -1, 1'b0);
    n_tests++; if (out0 !== 32'h7F7F7F7F) begin n_fail++; $display("FAIL sat_neg_lin: got %h want 7f7f7f7f", out0); end
    run_watch(32'h7F7F7F7F, 1'b0, 16, -1, 1'b0);
    n_tests++; if (out0 !== 32'h00000000) begin n_fail++; $display("FAIL sat_neg_relu: got %h want 00000000", out0); end
  endtask

  task automatic test_frac();
    for (int j = 0; j < 4; j++) mem1[j] = 32'h4 << (8 * j);
    for (int j = 4; j < 8; j++) mem1[j] = 32'h2 << (8 * (j - 4));
    run_watch(32'h08080808, 1'b1, 16, -1, 1'b0);
    n_tests++; if (out1 !== 32'h04040404) begin n_fail++; $display("FAIL frac_out: got %h want 04040404", out1); end
    n_tests++; if (first_done1 !== 13) begin n_fail++; $display("FAIL frac_done_cycle: got %0d want 13", first_done1); end
    run_watch(32'hFF0308F8, 1'b1, 16, -1, 1'b0);
    n_tests++; if (out1 !== 32'hFF0104FC) begin n_fail++; $display("FAIL frac_signed: got %h want ff0104fc", out1); end
  endtask

  task automatic test_start_ignored();
    load_identity();
    run_watch(32'h0007FD05, 1'b1, 20, 5, 1'b0);
    n_tests++; if (out0 !== 32'h0007FD05) begin n_fail++; $display("FAIL busy_start_out: got %h want 0007fd05", out0); end
    n_tests++; if (first_done !== 13) begin n_fail++; $display("FAIL busy_start_done: got %0d want 13", first_done); end
    n_tests++; if (done_cnt !== 1) begin n_fail++; $display("FAIL busy_start_count: got %0d want 1", done_cnt); end
    run_watch(32'h0007FD05, 1'b1, 20, 13, 1'b0);
    n_tests++; if (done_cnt !== 1) begin n_fail++; $display("FAIL done_start_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_back_to_back();
    load_identity();
    run_watch(32'h0007FD05, 1'b1, 30, -1, 1'b1);
    n_tests++; if (first_done !== 13) begin n_fail++; $display("FAIL b2b_first_done: got %0d want 13", first_done); end
    n_tests++; if (second_done !== 27) begin n_fail++; $display("FAIL b2b_second_done: got %0d want 27", second_done); end
    n_tests++; if (done_cnt !== 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 2", done_cnt); end
    n_tests++; if (out0 !== 32'h0007FD05) begin n_fail++; $display("FAIL b2b_out: got %h want 0007fd05", out0); end
  endtask

  task automatic test_mid_reset();
    int dcount;
    load_identity();
    @(negedge clk);
    in_data = 32'h0007FD05; act_sel = 1'b1; start = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    n_tests++; if (w_rd0 !== 1'b1) begin n_fail++; $display("FAIL pre_reset_w_rd: got %b want 1", w_rd0); end
    n_tests++; if (w_addr0 !== AW'(4)) begin n_fail++; $display("FAIL pre_reset_w_addr: got %0d want 4", w_addr0); end
    reset = 1'b0;
    #1;
    n_tests++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy0); end
    n_tests++; if (w_rd0 !== 1'b0) begin n_fail++; $display("FAIL midrst_w_rd: got %b want 0", w_rd0); end
    n_tests++; if (w_addr0 !== '0) begin n_fail++; $display("FAIL midrst_w_addr: got %0d want 0", w_addr0); end
    n_tests++; if (out0 !== 32'h0) begin n_fail++; $display("FAIL midrst_out: got %h want 0", out0); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    dcount = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done0) dcount++;
    end
    n_tests++; if (dcount !== 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d want 0", dcount); end
    run_watch(32'h04030201, 1'b1, 16, -1, 1'b0);
    n_tests++; if (out0 !== 32'h04030201) begin n_fail++; $display("FAIL post_reset_out: got %h want 04030201", out0); end
    n_tests++; if (first_done !== 13) begin n_fail++; $display("FAIL post_reset_done: got %0d want 13", first_done); end
  endtask

  initial begin
    for (int j = 0; j < 8; j++) begin
      mem0[j] = '0;
      mem1[j] = '0;
    end
    test_reset();
    test_identity_linear();
    test_relu_addr();
    test_saturation();
    test_frac();
    test_start_ignored();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
